// File: rtl/ir_pkg.sv
// Shared IR frame constants, accept windows and receiver/transmitter state enum.
package ir_pkg;

  localparam int FRAME_BITS = 67;
  localparam int GAP_BIT    = 35;
  localparam int DUR_W      = 11;

  localparam logic [DUR_W-1:0] DUR_SAT        = 11'd2047;
  localparam logic [DUR_W-1:0] LEAD_MARK_MIN  = 11'd300;
  localparam logic [DUR_W-1:0] LEAD_MARK_MAX  = 11'd380;
  localparam logic [DUR_W-1:0] LEAD_SPACE_MIN = 11'd150;
  localparam logic [DUR_W-1:0] LEAD_SPACE_MAX = 11'd190;
  localparam logic [DUR_W-1:0] MARK_MIN       = 11'd16;
  localparam logic [DUR_W-1:0] MARK_MAX       = 11'd32;
  localparam logic [DUR_W-1:0] ZERO_MIN       = 11'd14;
  localparam logic [DUR_W-1:0] ZERO_MAX       = 11'd40;
  localparam logic [DUR_W-1:0] ONE_MIN        = 11'd41;
  localparam logic [DUR_W-1:0] ONE_MAX        = 11'd85;
  localparam logic [DUR_W-1:0] GAP_MIN        = 11'd680;
  localparam logic [DUR_W-1:0] GAP_MAX        = 11'd840;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, GAP_MARK, GAP, STOP_MARK
  } ir_state_t;

  function automatic logic in_window(input logic [DUR_W-1:0] d,
                                     input logic [DUR_W-1:0] lo,
                                     input logic [DUR_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_rx_filter.sv
// Two-flop synchronizer for the IR envelope, with an optional 4-cycle
// stability filter enabled by IR_RX_GLITCH_FILTER_EN.
module ir_rx_filter (
  input  logic clk,
  input  logic rst,
  input  logic ir_in,
  output logic ir_sync
);

  logic [1:0] sync;

  // Two-stage synchronizer into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], ir_in};
  end

`ifdef IR_RX_GLITCH_FILTER_EN
  logic       level;
  logic [1:0] stable_cnt;

  // A new level is taken only after four consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= 1'b0;
      stable_cnt <= 2'd0;
    end else if (sync[1] != level) begin
      if (stable_cnt == 2'd3) begin
        level      <= sync[1];
        stable_cnt <= 2'd0;
      end else begin
        stable_cnt <= stable_cnt + 2'd1;
      end
    end else begin
      stable_cnt <= 2'd0;
    end
  end

  assign ir_sync = level;
`else
  assign ir_sync = sync[1];
`endif

endmodule

// File: rtl/ir_rx_decoder.sv
// Pulse-distance IR frame decoder (67 bits, mid-frame gap after bit 35).
// Optional glitch filter in ir_rx_filter via IR_RX_GLITCH_FILTER_EN.
module ir_rx_decoder
  import ir_pkg::*;
#(
  parameter int TICK_DIV = 1322
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ir_in,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]      pre;
  logic                  tick;
  logic                  line, line_d, rise, fall;
  logic [DUR_W-1:0]      dur;
  ir_state_t             state, state_next;
  logic [6:0]            bit_cnt, bit_cnt_next, bit_idx;
  logic [FRAME_BITS-1:0] shadow, shadow_next;
  logic                  valid_next, err_next, load_frame;

  ir_rx_filter u_filter (
    .clk     (clk),
    .rst     (rst),
    .ir_in   (ir_in),
    .ir_sync (line)
  );

  assign tick    = (pre == PRE_LAST);
  assign rise    = line & ~line_d;
  assign fall    = ~line & line_d;
  assign bit_idx = 7'(FRAME_BITS - 1) - bit_cnt;

  // Free-running tick prescaler and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre    <= '0;
      line_d <= 1'b0;
    end else begin
      pre    <= tick ? '0 : pre + PRE_W'(1);
      line_d <= line;
    end
  end

  // Phase duration: restarts on each edge, counting the edge cycle's tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          dur <= '0;
    else if (rise | fall)             dur <= {{(DUR_W-1){1'b0}}, tick};
    else if (tick && dur != DUR_SAT)  dur <= dur + 11'd1;
    else                              dur <= dur;
  end

  // Next-state, bit capture and outcome decode
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shadow_next  = shadow;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    load_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next   = LEAD_MARK;
          bit_cnt_next = 7'd0;
        end else begin
          state_next = IDLE;
        end
      end
      LEAD_MARK: begin
        if (fall) begin
          if (in_window(dur, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_next = LEAD_SPACE;
          else                                              err_next   = 1'b1;
        end else if (dur > LEAD_MARK_MAX) err_next = 1'b1;
        else                              state_next = state;
      end
      LEAD_SPACE: begin
        if (rise) begin
          if (in_window(dur, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) state_next = BIT_MARK;
          else                                                err_next   = 1'b1;
        end else if (dur > LEAD_SPACE_MAX) err_next = 1'b1;
        else                               state_next = state;
      end
      BIT_MARK, GAP_MARK, STOP_MARK: begin
        if (fall) begin
          if (!in_window(dur, MARK_MIN, MARK_MAX)) begin
            err_next = 1'b1;
          end else if (state == BIT_MARK) begin
            state_next = BIT_SPACE;
          end else if (state == GAP_MARK) begin
            state_next = GAP;
          end else begin
            state_next = IDLE;
            valid_next = 1'b1;
            load_frame = 1'b1;
          end
        end else if (dur > MARK_MAX) err_next = 1'b1;
        else                         state_next = state;
      end
      BIT_SPACE: begin
        if (rise) begin
          if (in_window(dur, ZERO_MIN, ONE_MAX)) begin
            // Space length carries the bit; first bit lands in the MSB
            shadow_next[bit_idx] = (dur >= ONE_MIN);
            bit_cnt_next         = bit_cnt + 7'd1;
            if (bit_cnt_next == 7'(GAP_BIT))         state_next = GAP_MARK;
            else if (bit_cnt_next == 7'(FRAME_BITS)) state_next = STOP_MARK;
            else                                     state_next = BIT_MARK;
          end else begin
            err_next = 1'b1;
          end
        end else if (dur > ONE_MAX) err_next = 1'b1;
        else                        state_next = state;
      end
      GAP: begin
        if (rise) begin
          if (in_window(dur, GAP_MIN, GAP_MAX)) state_next = BIT_MARK;
          else                                  err_next   = 1'b1;
        end else if (dur > GAP_MAX) err_next = 1'b1;
        else                        state_next = state;
      end
      default: state_next = IDLE;
    endcase
    state_next = err_next ? IDLE : state_next;
  end

  // FSM state, capture registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 7'd0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shadow      <= shadow_next;
      frame       <= load_frame ? shadow : frame;
      frame_valid <= valid_next;
      frame_err   <= err_next;
      busy        <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_ir_rx_decoder.sv
// Directed self-checking bench for ir_rx_decoder (TICK_DIV = 2).
module tb_ir_rx_decoder;

  localparam int DIV = 2;
`ifdef IR_RX_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam logic [66:0] OPEN_FRAME  = 67'h24940280502020000;
  localparam logic [66:0] CLOSE_FRAME = 67'h64940280502420001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_in = 1'b0;
  logic [66:0] frame;
  logic        frame_valid, frame_err, busy;

  int   n_checks = 0;
  int   n_fail = 0;
  int   valid_cnt = 0;
  int   err_cnt = 0;
  logic both_seen = 1'b0;

  ir_rx_decoder #(.TICK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in),
    .frame(frame), .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) valid_cnt <= valid_cnt + 1;
    if (frame_err)   err_cnt   <= err_cnt + 1;
    if (frame_valid && frame_err) both_seen <= 1'b1;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic lvl, input int ticks);
    ir_in = lvl;
    repeat (ticks * DIV) @(negedge clk);
  endtask

  task automatic send_bits(input logic [66:0] data, input int nbits, input bit glitch);
    if (glitch) begin
      hold(1'b1, 100);
      ir_in = 1'b0;
      repeat (2) @(negedge clk);
      hold(1'b1, 237);
    end else begin
      hold(1'b1, 338);
    end
    hold(1'b0, 171);
    for (int k = 1; k <= nbits; k++) begin
      hold(1'b1, 24);
      hold(1'b0, data[67-k] ? 63 : 21);
      if (k == 35 && k < nbits) begin
        hold(1'b1, 24);
        hold(1'b0, 760);
      end
    end
  endtask

  task automatic send_frame(input logic [66:0] data);
    send_bits(data, 67, 1'b0);
    hold(1'b1, 24);
    hold(1'b0, 100);
  endtask

  task automatic test_reset;
    repeat (4) @(negedge clk);
    n_checks++; if (frame !== 67'd0) begin n_fail++; $display("FAIL reset_frame: got %h expected 0", frame); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_frame;
    int v0;
    v0 = valid_cnt;
    send_bits(OPEN_FRAME, 67, 1'b0);
    hold(1'b1, 24);
    ir_in = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL valid_early: got %b expected 0", frame_valid); end
    @(negedge clk);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL valid_latency: got %b expected 1", frame_valid); end
    n_checks++; if (frame !== OPEN_FRAME) begin n_fail++; $display("FAIL open_frame: got %h expected %h", frame, OPEN_FRAME); end
    @(negedge clk);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL valid_width: got %b expected 0", frame_valid); end
    hold(1'b0, 100);
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL open_valid_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL open_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_lead_err;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b1, 100);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lead_busy: got %b expected 1", busy); end
    hold(1'b1, 150);
    ir_in = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL lead_err_early: got %b expected 0", frame_err); end
    @(negedge clk);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL lead_err_pulse: got %b expected 1", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lead_err_busy: got %b expected 0", busy); end
    hold(1'b0, 200);
    n_checks++; if (frame !== OPEN_FRAME) begin n_fail++; $display("FAIL lead_err_frame: got %h expected %h", frame, OPEN_FRAME); end
    n_checks++; if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
      n_fail++; $display("FAIL lead_err_counts: got err %0d valid %0d expected err 1 valid 0", err_cnt - e0, valid_cnt - v0);
    end
  endtask

  task automatic test_gap_timeout;
    int n;
    send_bits(CLOSE_FRAME, 35, 1'b0);
    hold(1'b1, 24);
    ir_in = 1'b0;
    n = 0;
    while (frame_err !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (n < 1684 + LAT - 3 || n > 1685 + LAT - 3) begin
      n_fail++; $display("FAIL gap_timeout_cycle: got %0d expected %0d..%0d", n, 1684 + LAT - 3, 1685 + LAT - 3);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_timeout_busy: got %b expected 0", busy); end
    repeat (1000 * DIV - n) @(negedge clk);
    n_checks++; if (frame !== OPEN_FRAME) begin n_fail++; $display("FAIL gap_timeout_frame: got %h expected %h", frame, OPEN_FRAME); end
  endtask

  task automatic test_reset_mid_frame;
    int e0;
    send_bits(CLOSE_FRAME, 19, 1'b0);
    hold(1'b1, 10);
    e0 = err_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (frame !== 67'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got frame %h valid %b err %b busy %b expected all 0", frame, frame_valid, frame_err, busy);
    end
    ir_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 50);
    n_checks++; if (err_cnt !== e0) begin n_fail++; $display("FAIL midreset_no_err: got %0d expected %0d", err_cnt, e0); end
    send_frame(CLOSE_FRAME);
    n_checks++; if (frame !== CLOSE_FRAME) begin n_fail++; $display("FAIL close_frame: got %h expected %h", frame, CLOSE_FRAME); end
  endtask

  task automatic test_back_to_back;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(OPEN_FRAME);
    n_checks++; if (frame !== OPEN_FRAME) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", frame, OPEN_FRAME); end
    send_bits(CLOSE_FRAME, 40, 1'b0);
    hold(1'b1, 24);
    hold(1'b0, 200);
    n_checks++; if (frame !== OPEN_FRAME) begin n_fail++; $display("FAIL b2b_truncated: got %h expected %h", frame, OPEN_FRAME); end
    send_frame(OPEN_FRAME);
    n_checks++; if (frame !== OPEN_FRAME) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", frame, OPEN_FRAME); end
    n_checks++; if (valid_cnt - v0 !== 2 || err_cnt - e0 !== 1) begin
      n_fail++; $display("FAIL b2b_counts: got valid %0d err %0d expected valid 2 err 1", valid_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(CLOSE_FRAME, 67, 1'b1);
    hold(1'b1, 24);
    hold(1'b0, 200);
`ifdef IR_RX_GLITCH_FILTER_EN
    n_checks++; if (frame !== CLOSE_FRAME) begin n_fail++; $display("FAIL glitch_frame: got %h expected %h", frame, CLOSE_FRAME); end
    n_checks++; if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
      n_fail++; $display("FAIL glitch_counts: got valid %0d err %0d expected valid 1 err 0", valid_cnt - v0, err_cnt - e0);
    end
`else
    n_checks++; if (frame !== OPEN_FRAME) begin n_fail++; $display("FAIL glitch_frame: got %h expected %h", frame, OPEN_FRAME); end
    n_checks++; if (valid_cnt - v0 !== 0 || err_cnt - e0 < 1) begin
      n_fail++; $display("FAIL glitch_counts: got valid %0d err %0d expected valid 0 err >=1", valid_cnt - v0, err_cnt - e0);
    end
`endif
  endtask

  task automatic test_exclusive;
    n_checks++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL valid_err_overlap: got %b expected 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_lead_err();
    test_gap_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_glitch();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
